// File: rtl/ws2812b_frame_sched.sv
// WS2812B frame scheduler: fetches NUM_LEDS pixels, serialises them MSB first, then holds latch for the reset gap.
// Optional WS2812B_BRIGHTNESS_EN adds an 8-bit bright input that scales each channel as (ch*(bright+1))>>8.
module ws2812b_frame_sched #(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned RESET_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
`ifdef WS2812B_BRIGHTNESS_EN
    input  logic [7:0]  bright,
`endif
    output logic        busy,
    output logic        done,
    output logic [7:0]  pix_addr,
    output logic        pix_rd,
    input  logic [23:0] pix_data,
    output logic        bit_data,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        latch
);

    localparam int unsigned LAT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYCLES - 1);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       pix_addr_q;
    logic             pix_rd_q;
    logic             rd_dly_q;
    logic             bit_valid_q;
    logic             latch_q;
    logic [7:0]       idx_q;
    logic [4:0]       cnt_q;
    logic [23:0]      sh_q;
    logic [23:0]      hold_q;
    logic [LAT_W-1:0] lat_q;
    logic [23:0]      pix_in;

`ifdef WS2812B_BRIGHTNESS_EN
    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, ch} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    assign pix_in = {scale_ch(pix_data[23:16], bright),
                     scale_ch(pix_data[15:8],  bright),
                     scale_ch(pix_data[7:0],   bright)};
`else
    assign pix_in = pix_data;
`endif

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_addr_q  <= '0;
            pix_rd_q    <= 1'b0;
            rd_dly_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            latch_q     <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            lat_q       <= '0;
        end else begin
            done_q   <= 1'b0;
            pix_rd_q <= 1'b0;
            rd_dly_q <= pix_rd_q;
            case (state_q)
                S_IDLE: begin
                    // The done cycle is still IDLE, so start must be masked there explicitly.
                    if (start && !done_q) begin
                        state_q    <= S_FETCH;
                        busy_q     <= 1'b1;
                        idx_q      <= '0;
                        pix_addr_q <= '0;
                        pix_rd_q   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    sh_q    <= pix_in;
                    cnt_q   <= '0;
                    state_q <= S_SHIFT;
                    if (idx_q != LAST_IDX) begin
                        pix_rd_q   <= 1'b1;
                        pix_addr_q <= idx_q + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (rd_dly_q) begin
                        hold_q <= pix_in;
                    end
                    if (!bit_valid_q) begin
                        bit_valid_q <= 1'b1;
                    end else if (bit_ready) begin
                        if (cnt_q == 5'd23) begin
                            cnt_q <= '0;
                            if (idx_q != LAST_IDX) begin
                                // Seamless hand-over to the prefetched pixel, then prefetch the one after.
                                sh_q  <= hold_q;
                                idx_q <= idx_q + 8'd1;
                                if ((idx_q + 8'd1) != LAST_IDX) begin
                                    pix_rd_q   <= 1'b1;
                                    pix_addr_q <= idx_q + 8'd2;
                                end
                            end else begin
                                sh_q        <= {sh_q[22:0], 1'b0};
                                bit_valid_q <= 1'b0;
                                latch_q     <= 1'b1;
                                lat_q       <= '0;
                                state_q     <= S_LATCH;
                            end
                        end else begin
                            sh_q  <= {sh_q[22:0], 1'b0};
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                S_LATCH: begin
                    if (lat_q == LAT_LAST) begin
                        latch_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_addr  = pix_addr_q;
    assign pix_rd    = pix_rd_q;
    assign bit_data  = sh_q[23];
    assign bit_valid = bit_valid_q;
    assign latch     = latch_q;

endmodule

// File: tb/tb_ws2812b_frame_sched.sv
// Self-checking bench for ws2812b_frame_sched: table-driven frames with a bit scoreboard, plus corner sequences.
// Build with WS2812B_BRIGHTNESS_EN defined to include the brightness-scaling vector.
`timescale 1ns/1ps
module tb_ws2812b_frame_sched;

    typedef struct {
        logic [23:0] w0;
        logic [23:0] w1;
        int          mode;   // bit_ready: 0 tied high, 1 toggling, 2 random
        logic [7:0]  br;
        logic [23:0] e0;
        logic [23:0] e1;
    } vec_t;

    localparam logic [23:0] W_SINGLE = 24'hC3A50F;

    logic        clk = 1'b0;
    logic        res;
    logic        start2, start1;
    logic        busy2, done2, pix_rd2, bit_data2, bit_valid2, latch2;
    logic        busy1, done1, pix_rd1, bit_data1, bit_valid1, latch1;
    logic [7:0]  pix_addr2, pix_addr1;
    logic [23:0] pix_data2, pix_data1;
    logic        bit_ready2, bit_ready1;
`ifdef WS2812B_BRIGHTNESS_EN
    logic [7:0]  bright2;
    logic [7:0]  bright1;
`endif

    logic [23:0] mem2 [2];
    int          mode2;
    int          checks = 0;
    int          errors = 0;

    logic        exp_q  [$];
    logic        exp1_q [$];
    int          xfer_cnt2, vcyc2, lat_cnt2, done_cnt2, rd_exp2;
    int          xfer_cnt1, lat_cnt1, done_cnt1, rd_cnt1;
    logic        pv2 = 1'b0, pr2 = 1'b0, pd2 = 1'b0;

    always #5 clk = ~clk;

    ws2812b_frame_sched #(.NUM_LEDS(2), .RESET_CYCLES(2500)) dut2 (
        .clk(clk), .res(res), .start(start2),
`ifdef WS2812B_BRIGHTNESS_EN
        .bright(bright2),
`endif
        .busy(busy2), .done(done2), .pix_addr(pix_addr2), .pix_rd(pix_rd2),
        .pix_data(pix_data2), .bit_data(bit_data2), .bit_valid(bit_valid2),
        .bit_ready(bit_ready2), .latch(latch2)
    );

    ws2812b_frame_sched #(.NUM_LEDS(1), .RESET_CYCLES(16)) dut1 (
        .clk(clk), .res(res), .start(start1),
`ifdef WS2812B_BRIGHTNESS_EN
        .bright(bright1),
`endif
        .busy(busy1), .done(done1), .pix_addr(pix_addr1), .pix_rd(pix_rd1),
        .pix_data(pix_data1), .bit_data(bit_data1), .bit_valid(bit_valid1),
        .bit_ready(bit_ready1), .latch(latch1)
    );

    // Pixel memories: data valid only in the cycle after pix_rd, junk otherwise.
    always @(posedge clk) begin
        if (pix_rd2) pix_data2 <= (pix_addr2 < 8'd2) ? mem2[pix_addr2[0]] : 24'h5A5A5A;
        else         pix_data2 <= 24'h5A5A5A;
        if (pix_rd1) pix_data1 <= W_SINGLE;
        else         pix_data1 <= 24'hA5A5A5;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (res) begin
            if (bit_valid2 && bit_ready2) begin
                xfer_cnt2++;
                if (exp_q.size() == 0) chk("extra_bit", 1, 0);
                else chk("bit", {31'd0, bit_data2}, {31'd0, exp_q.pop_front()});
            end
            if (pv2 && !pr2) chk("stall_hold", {30'd0, bit_valid2, bit_data2}, {30'd0, 1'b1, pd2});
            if (pix_rd2) begin
                chk("rd_addr", {24'd0, pix_addr2}, rd_exp2);
                rd_exp2++;
            end
            if (bit_valid2) vcyc2++;
            if (latch2)     lat_cnt2++;
            if (done2)      done_cnt2++;

            if (bit_valid1 && bit_ready1) begin
                xfer_cnt1++;
                if (exp1_q.size() == 0) chk("extra_bit1", 1, 0);
                else chk("bit1", {31'd0, bit_data1}, {31'd0, exp1_q.pop_front()});
            end
            if (pix_rd1) begin
                rd_cnt1++;
                chk("rd1_addr", {24'd0, pix_addr1}, 0);
            end
            if (latch1) lat_cnt1++;
            if (done1)  done_cnt1++;
        end
        pv2 = bit_valid2;
        pr2 = bit_ready2;
        pd2 = bit_data2;
    end

    initial begin
        bit_ready2 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode2)
                0:       bit_ready2 = 1'b1;
                1:       bit_ready2 = ~bit_ready2;
                default: bit_ready2 = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic clear2();
        xfer_cnt2 = 0; vcyc2 = 0; lat_cnt2 = 0; done_cnt2 = 0; rd_exp2 = 0;
    endtask

    task automatic push_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic wait_done2(output bit got, input int max_cyc);
        got = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (done2) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input vec_t v);
        int k;
        bit got;
        mode2   = v.mode;
        mem2[0] = v.w0;
        mem2[1] = v.w1;
`ifdef WS2812B_BRIGHTNESS_EN
        bright2 = v.br;
`endif
        clear2();
        push_word(v.e0);
        push_word(v.e1);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        k = 0;
        while (!bit_valid2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("first_valid_latency", k, 4);
        chk("busy_in_frame", {31'd0, busy2}, 1);
        wait_done2(got, 20000);
        chk("done_seen", {31'd0, got}, 1);
        @(posedge clk);
        #1;
        chk("done_pulses", done_cnt2, 1);
        chk("done_one_cycle", {31'd0, done2}, 0);
        chk("latch_cycles", lat_cnt2, 2500);
        chk("bits_xfer", xfer_cnt2, 48);
        chk("sb_empty", exp_q.size(), 0);
        chk("rd_count", rd_exp2, 2);
        chk("busy_after", {31'd0, busy2}, 0);
        if (v.mode == 0) chk("contig_valid", vcyc2, 48);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [$];
        bit   got;
        tbl.push_back('{24'hFF0000, 24'h00000F, 0, 8'hFF, 24'hFF0000, 24'h00000F});
        tbl.push_back('{24'hFF0000, 24'h00000F, 1, 8'hFF, 24'hFF0000, 24'h00000F});
        tbl.push_back('{24'hA5C33C, 24'h5AF00F, 2, 8'hFF, 24'hA5C33C, 24'h5AF00F});
        tbl.push_back('{24'h800001, 24'h000080, 1, 8'hFF, 24'h800001, 24'h000080});
`ifdef WS2812B_BRIGHTNESS_EN
        tbl.push_back('{24'hFF8002, 24'h00000F, 0, 8'h7F, 24'h7F4001, 24'h000007});
        bright2 = 8'hFF;
        bright1 = 8'hFF;
`endif
        res = 1'b0; start2 = 1'b0; start1 = 1'b0; bit_ready1 = 1'b1; mode2 = 0;
        mem2[0] = '0; mem2[1] = '0;
        clear2();
        xfer_cnt1 = 0; lat_cnt1 = 0; done_cnt1 = 0; rd_cnt1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs2", {19'd0, busy2, done2, pix_rd2, bit_valid2, bit_data2, latch2, pix_addr2}, 0);
        chk("reset_outputs1", {19'd0, busy1, done1, pix_rd1, bit_valid1, bit_data1, latch1, pix_addr1}, 0);
        res = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < tbl.size(); t++) run_frame(tbl[t]);

        // start held high for a whole frame: one frame, restart only after the done cycle
        mode2 = 0; mem2[0] = 24'hFF0000; mem2[1] = 24'h00000F;
`ifdef WS2812B_BRIGHTNESS_EN
        bright2 = 8'hFF;
`endif
        clear2();
        push_word(24'hFF0000);
        push_word(24'h00000F);
        start2 = 1'b1;
        wait_done2(got, 20000);
        chk("held_done_seen", {31'd0, got}, 1);
        @(posedge clk);
        #1;
        chk("held_one_frame", done_cnt2, 1);
        chk("held_bits", xfer_cnt2, 48);
        chk("held_ignored_in_done", {30'd0, busy2, pix_rd2}, 0);
        clear2();
        push_word(24'hFF0000);
        push_word(24'h00000F);
        @(posedge clk);
        #1;
        chk("held_restart", {22'd0, busy2, pix_rd2, pix_addr2}, {22'd0, 1'b1, 1'b1, 8'h00});
        start2 = 1'b0;
        wait_done2(got, 20000);
        chk("held2_done_seen", {31'd0, got}, 1);
        @(posedge clk);
        #1;
        chk("held2_done_pulses", done_cnt2, 1);
        chk("held2_bits", xfer_cnt2, 48);
        chk("held2_rd_count", rd_exp2, 2);
        chk("held2_sb_empty", exp_q.size(), 0);

        // reset while bit 30 is presented
        mode2 = 0; mem2[0] = 24'hA5C33C; mem2[1] = 24'h5AF00F;
        clear2();
        push_word(24'hA5C33C);
        push_word(24'h5AF00F);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int c = 0; c < 100 && xfer_cnt2 != 29; c++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_reached_bit30", xfer_cnt2, 29);
        res = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_outputs", {29'd0, bit_valid2, busy2, latch2}, 0);
        res = 1'b1;
        vcyc2 = 0; lat_cnt2 = 0; done_cnt2 = 0;
        repeat (3000) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt2, 0);
        chk("abort_no_valid", vcyc2, 0);
        chk("abort_no_latch", lat_cnt2, 0);
        exp_q.delete();

        // single-LED chain
        for (int i = 23; i >= 0; i--) exp1_q.push_back(W_SINGLE[i]);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (done1) begin
                got = 1'b1;
                break;
            end
        end
        chk("one_done_seen", {31'd0, got}, 1);
        @(posedge clk);
        #1;
        chk("one_rd_count", rd_cnt1, 1);
        chk("one_bits", xfer_cnt1, 24);
        chk("one_latch_cycles", lat_cnt1, 16);
        chk("one_done_pulses", done_cnt1, 1);
        chk("one_sb_empty", exp1_q.size(), 0);
        chk("one_busy_after", {31'd0, busy1}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
